// File: rtl/core_output_ctrl.sv
// Output de-skew controller: collects skewed per-lane results from the array and emits aligned rows.
// Latency: last missing element presented in cycle c gives out_valid in cycle c+2; one row per cycle sustained.
// Backpressure: out_ready low holds outport/out_valid; lanes keep filling, pushes to full non-popping lanes drop and set overflow.
//
// Ports:
//   clk, rst              : single clock, synchronous active-high reset
//   colvalid, colin       : per-lane result element strobe and data
//   out_valid, out_ready  : registered valid/ready row handoff toward writeback
//   outport               : aligned row, element i from lane i
//   lemptys, lfulls       : per-lane FIFO empty/full, decoded from the lane count
//   overflow              : sticky flag, a push to a full lane was dropped
//   rowcount              : number of rows handed off, wraps at 2^16
module core_output_ctrl #(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:LANES-1]      colvalid,
  input  logic [DW-1:0]         colin [0:LANES-1],
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         outport [0:LANES-1],
  output logic [0:LANES-1]      lemptys,
  output logic [0:LANES-1]      lfulls,
  output logic                  overflow,
  output logic [15:0]           rowcount
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLCNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [0:LANES-1][0:DEPTH-1];
  logic [AW-1:0] rdp [0:LANES-1];
  logic [AW-1:0] wrp [0:LANES-1];
  logic [AW:0]   cnt [0:LANES-1];

  logic             pop;
  logic [0:LANES-1] push_ok;
  logic [0:LANES-1] push_drop;

  always_comb begin
    lemptys   = '0;
    lfulls    = '0;
    push_ok   = '0;
    push_drop = '0;
    for (int i = 0; i < LANES; i++) begin
      lemptys[i] = (cnt[i] == '0);
      lfulls[i]  = (cnt[i] == FULLCNT);
    end
    // Pop whenever every lane has an element and the output register is free or being drained.
    pop = (&(~lemptys)) && (!out_valid || out_ready);
    for (int i = 0; i < LANES; i++) begin
      // A full lane still accepts a push when it pops in the same cycle.
      push_ok[i]   = colvalid[i] && (!lfulls[i] || pop);
      push_drop[i] = colvalid[i] && lfulls[i] && !pop;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (push_ok[i]) mem[i][wrp[i]] <= colin[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        rdp[i]     <= '0;
        wrp[i]     <= '0;
        cnt[i]     <= '0;
        outport[i] <= '0;
      end
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      rowcount  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_ok[i]) wrp[i] <= wrp[i] + 1'b1;
        if (pop)        rdp[i] <= rdp[i] + 1'b1;
        if (push_ok[i] && !pop)      cnt[i] <= cnt[i] + 1'b1;
        else if (!push_ok[i] && pop) cnt[i] <= cnt[i] - 1'b1;
      end

      if (pop) begin
        for (int i = 0; i < LANES; i++) outport[i] <= mem[i][rdp[i]];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (|push_drop) overflow <= 1'b1;
      if (out_valid && out_ready) rowcount <= rowcount + 16'd1;
    end
  end

endmodule

// File: tb/tb_core_output_ctrl.sv
// Bench for core_output_ctrl: queue-based reference model compared every cycle, plus directed scenarios
// with literal expectations for latency, ordering, backpressure, overflow and push/pop at full.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_core_output_ctrl;
  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [0:LANES-1]  colvalid = '1;
  logic [DW-1:0]     colin [0:LANES-1];
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DW-1:0]     outport [0:LANES-1];
  logic [0:LANES-1]  lemptys;
  logic [0:LANES-1]  lfulls;
  logic              overflow;
  logic [15:0]       rowcount;

  core_output_ctrl #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .colvalid(colvalid), .colin(colin), .out_ready(out_ready),
    .out_valid(out_valid), .outport(outport), .lemptys(lemptys), .lfulls(lfulls),
    .overflow(overflow), .rowcount(rowcount)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per lane plus the output register and counters.
  logic [DW-1:0] q [0:LANES-1][$];
  logic          m_valid;
  logic [DW-1:0] m_out [0:LANES-1];
  logic          m_ovf;
  logic [15:0]   m_rc;
  bit            live = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        q[i].delete();
        m_out[i] = '0;
      end
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_rc    = '0;
      live    = 1;
    end else begin
      bit allne;
      bit mpop;
      allne = 1;
      for (int i = 0; i < LANES; i++) if (q[i].size() == 0) allne = 0;
      mpop = allne && (!m_valid || out_ready);
      if (m_valid && out_ready) m_rc = m_rc + 16'd1;
      if (mpop) begin
        for (int i = 0; i < LANES; i++) m_out[i] = q[i].pop_front();
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (colvalid[i]) begin
          if (q[i].size() < DEPTH) q[i].push_back(colin[i]);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      check("out_valid", out_valid, m_valid);
      check("overflow", overflow, m_ovf);
      check("rowcount", rowcount, m_rc);
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("outport[%0d]", i), outport[i], m_out[i]);
        check($sformatf("lemptys[%0d]", i), lemptys[i], q[i].size() == 0);
        check($sformatf("lfulls[%0d]", i), lfulls[i], q[i].size() == DEPTH);
      end
    end
  end

  task automatic set_all(input logic [0:LANES-1] v, input logic [DW-1:0] val);
    colvalid = v;
    for (int i = 0; i < LANES; i++) colin[i] = val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    set_all('1, 32'hAA);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_all('0, 32'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lemptys", lemptys, {LANES{1'b1}});
    check("rst_lfulls", lfulls, {LANES{1'b0}});
    check("rst_overflow", overflow, 1'b0);
    check("rst_rowcount", rowcount, 16'd0);
    check("rst_outport0", outport[0], 32'd0);
  endtask

  // Fill with 9 aligned rows (value r on every lane) while out_ready is low.
  task automatic fill9();
    out_ready = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      @(negedge clk);
      set_all('1, DW'(r));
    end
    @(negedge clk);
    set_all('0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) colin[i] = 32'hAA;
    do_reset();

    // Skewed single row: lane k presents k+1 in cycle k; row expected only in cycle 9.
    out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      check($sformatf("skew_valid_c%0d", k), out_valid, k == 9);
      if (k == 9)
        for (int i = 0; i < LANES; i++) check($sformatf("skew_out[%0d]", i), outport[i], DW'(i + 1));
      set_all('0, 32'h0);
      if (k < LANES) begin
        colvalid[k] = 1'b1;
        colin[k]    = DW'(k + 1);
      end
    end
    check("skew_rowcount", rowcount, 16'd1);
    check("skew_empty", lemptys, {LANES{1'b1}});

    // Streaming: 16 skewed rows, row r lane i = r*16+i, expected on cycles 9..24.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      check($sformatf("strm_valid_c%0d", k), out_valid, (k >= 9) && (k <= 24));
      if (k >= 9 && k <= 24)
        for (int i = 0; i < LANES; i++)
          check($sformatf("strm_out_c%0d[%0d]", k, i), outport[i], DW'((k - 9) * 16 + i));
      for (int i = 0; i < LANES; i++) begin
        colvalid[i] = (k - i >= 0) && (k - i < 16);
        colin[i]    = DW'((k - i) * 16 + i);
      end
    end
    check("strm_rowcount", rowcount, 16'd16);

    // Backpressure then overflow on lane 3.
    do_reset();
    fill9();
    check("bp_valid", out_valid, 1'b1);
    check("bp_out0", outport[0], 32'd1);
    check("bp_out7", outport[7], 32'd1);
    check("bp_full", lfulls, {LANES{1'b1}});
    check("bp_no_ovf", overflow, 1'b0);
    colvalid[3] = 1'b1;
    colin[3]    = 32'h99;
    @(negedge clk);
    colvalid = '0;
    check("ovf_set", overflow, 1'b1);
    check("ovf_lane3_full", lfulls[3], 1'b1);
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("drain_valid_%0d", j), out_valid, j < 9);
      if (j < 9)
        for (int i = 0; i < LANES; i++)
          check($sformatf("drain_out_%0d[%0d]", j, i), outport[i], DW'(j + 1));
    end
    @(negedge clk);
    check("drain_empty", lemptys, {LANES{1'b1}});
    check("drain_ovf_sticky", overflow, 1'b1);
    check("drain_rowcount", rowcount, 16'd9);

    // Push of 0x55 on all lanes while full and draining: accepted, appears last.
    do_reset();
    fill9();
    out_ready = 1'b1;
    set_all('1, 32'h55);
    for (int j = 0; j < 11; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) begin
        set_all('0, 32'h0);
        check("pp_full_kept", lfulls, {LANES{1'b1}});
        check("pp_no_ovf", overflow, 1'b0);
      end
      check($sformatf("pp_valid_%0d", j), out_valid, j < 10);
      if (j < 10)
        for (int i = 0; i < LANES; i++)
          check($sformatf("pp_out_%0d[%0d]", j, i), outport[i], (j < 9) ? DW'(j + 1) : 32'h55);
    end
    check("pp_rowcount", rowcount, 16'd10);
    check("pp_ovf_end", overflow, 1'b0);
    check("pp_empty", lemptys, {LANES{1'b1}});

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/core_output_ctrl.md
# core_output_ctrl

Output-side counterpart of the core input controller: it collects results leaving the bottom of the systolic array, where lane i delivers its element of a result row i cycles after lane 0, and de-skews them into aligned full-width rows. Each lane has a small FIFO. A row is released only when every lane holds an element. Released rows go out on a registered valid/ready port toward writeback.

## Interface
Parameters:
- LANES, 8, number of array columns / result lanes
- DW, 32, result element width (accumulator width)
- DEPTH, 8, per-lane FIFO depth in entries; power of two, at least 2

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- colvalid  input  [0:LANES-1]  lane i presents a result element this cycle
- colin  input  [DW-1:0] x [0:LANES-1]  per-lane result data
- out_ready  input  1  downstream accepts outport this cycle
- out_valid  output  1  outport holds an aligned row
- outport  output  [DW-1:0] x [0:LANES-1]  aligned row, element i from lane i
- lemptys  output  [0:LANES-1]  lane FIFO empty, combinational from count
- lfulls  output  [0:LANES-1]  lane FIFO full, combinational from count
- overflow  output  1  sticky: a push to a full lane was dropped
- rowcount  output  16  rows handed off (out_valid && out_ready), wraps at 2^16

## Operation
- Lane FIFO:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
  - Push when colvalid[i].
  - Pop when the global pop signal is asserted.
- Pop condition:
  - pop = (&~lemptys) && (!out_valid || out_ready).
  - All lanes pop together in the same cycle.
- Output register:
  - On pop, outport is loaded with the head of every lane and out_valid is set.
  - Else if out_valid && out_ready, out_valid is cleared; outport holds its old value.
  - Else outport and out_valid hold.
- Push to a full lane:
  - If the lane pops in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the data is dropped, pointers and count are unchanged, and overflow is set and stays set until rst.
- Push and pop on the same lane in the same cycle (not full): the pop reads the old head, the push writes the tail, and count is unchanged.
- A pop on an empty lane is impossible by construction (pop requires all lanes non-empty).
- rowcount increments on each cycle with out_valid && out_ready, and wraps from 0xFFFF to 0.
- No per-row tagging. Order within a lane is strict FIFO, so row k is the k-th element of every lane.
- Reset values, all synchronous on rst:
  - pointers and counts 0
  - lemptys all 1
  - lfulls all 0
  - out_valid 0
  - outport all 0
  - overflow 0
  - rowcount 0
- Reset mid-operation: all in-flight lane data and any held output row are discarded. Inputs are ignored in the rst cycle.

## Timing
- Push is visible in lemptys/lfulls on the cycle after colvalid.
- Latency: if the last missing lane element of a row is presented in cycle c, out_valid is high in cycle c+2, assuming the output register is free or out_ready is high.
- Skewed input: row elements presented in cycles t..t+LANES-1 (lane i at t+i) give out_valid in cycle t+LANES+1.
- Throughput: one row per cycle while all lanes are non-empty and out_ready stays high.
- Backpressure: with out_ready low and out_valid high, no pop occurs. Lanes keep filling and reach full after DEPTH pushes, plus the row held in outport.
- out_valid and outport are stable while out_ready is low. Valid never deasserts without a handshake.

## Test plan
- Reset: hold rst 2 cycles, all colvalid high with colin=0xAA → after rst, out_valid=0, outport=0, lemptys=all 1, overflow=0, rowcount=0.
- Skewed single row: lane i presents colin=i+1 in cycle t+i, out_ready=1 → out_valid high only in cycle t+9, outport={1,2,...,8}, rowcount=1, all lanes empty afterward.
- Streaming: 16 skewed rows, row r lane i value r*16+i, out_ready=1 → 16 consecutive out_valid cycles starting t+9, values in order, rowcount=16.
- Backpressure: out_ready=0, push 9 aligned rows (values 1..9 on all lanes) → out_valid with row 1 held, 8 rows buffered, lfulls all 1. Then out_ready=1 → rows 1..9 in order on consecutive cycles, overflow=0.
- Overflow: continue from the full state with a 10th push on lane 3 only, out_ready=0 → overflow=1, lane 3 count stays 8. After draining, lane 3 holds no extra data and overflow stays 1 until rst.
- Simultaneous push/pop at full: all lanes full, out_valid high, out_ready=1 plus an aligned push of 0x55 → push accepted, no overflow, count stays 8, and 0x55 appears as the last drained row.
